// File: rtl/pp_reduce_pipe.sv
// Pipelined 3:2 carry-save reduction of N_OPS operands to a sum/carry pair,
// with valid/ready flow control and multi-beat group accumulation.
module pp_reduce_pipe #(
  parameter int unsigned SIG_WIDTH   = 23,
  parameter int unsigned N_OPS       = 18,
  parameter int unsigned OUT_W       = 56,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_first,
  input  logic                                     in_last,
  input  logic [N_OPS*(2*(SIG_WIDTH+1)+1)-1:0]     in_pp,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [OUT_W-1:0]                         out_sum,
  output logic [OUT_W-1:0]                         out_carry,
  output logic [7:0]                               out_beats
);

  localparam int unsigned IN_W = 2*(SIG_WIDTH+1)+1;
  localparam int unsigned P    = PIPE_STAGES;
  localparam int unsigned PR   = (P > 1) ? P-1 : 1;

  function automatic int unsigned next_cnt(input int unsigned n);
    return 2*(n/3) + n%3;
  endfunction

  function automatic int unsigned cnt_at(input int unsigned lvl);
    int unsigned n;
    n = N_OPS;
    for (int unsigned i = 0; i < lvl; i++) n = next_cnt(n);
    return n;
  endfunction

  function automatic int unsigned num_levels();
    int unsigned n;
    int unsigned lv;
    n  = N_OPS;
    lv = 0;
    while (n > 2) begin
      n  = next_cnt(n);
      lv = lv + 1;
    end
    return lv;
  endfunction

  localparam int unsigned L = num_levels();

  // Stage k (1..P-1) registers the output of tree level ceil(k*L/P).
  function automatic int unsigned stage_at(input int unsigned b);
    int unsigned r;
    r = 0;
    for (int unsigned k = 1; k < P; k++)
      if ((k*L + P - 1)/P == b) r = k;
    return r;
  endfunction

  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  genvar gl;
  for (gl = 0; gl <= L; gl++) begin : g_lvl
    localparam int unsigned NO = cnt_at(gl);
    logic [OUT_W-1:0] nd [NO];
    logic [OUT_W-1:0] nx [NO];

    if (gl == 0) begin : g_src
      always_comb
        for (int unsigned k = 0; k < NO; k++) nd[k] = OUT_W'(in_pp[k*IN_W +: IN_W]);
    end else begin : g_csa
      localparam int unsigned NI = cnt_at(gl-1);
      localparam int unsigned NG = NI/3;
      always_comb begin
        for (int unsigned g = 0; g < NG; g++) begin
          nd[2*g]   = g_lvl[gl-1].nx[3*g] ^ g_lvl[gl-1].nx[3*g+1] ^ g_lvl[gl-1].nx[3*g+2];
          nd[2*g+1] = ((g_lvl[gl-1].nx[3*g]   & g_lvl[gl-1].nx[3*g+1]) |
                       (g_lvl[gl-1].nx[3*g]   & g_lvl[gl-1].nx[3*g+2]) |
                       (g_lvl[gl-1].nx[3*g+1] & g_lvl[gl-1].nx[3*g+2])) << 1;
        end
        for (int unsigned r = 0; r < NI - 3*NG; r++) nd[2*NG+r] = g_lvl[gl-1].nx[3*NG+r];
      end
    end

    if (stage_at(gl) != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   nx <= '{default: '0};
        else if (adv) nx <= nd;
      end
    end else begin : g_pass
      assign nx = nd;
    end
  end

  logic [PR-1:0] v_q, f_q, l_q;
  logic          fin_v, fin_f, fin_l;

  if (P == 1) begin : g_fin_comb
    assign fin_v = in_valid;
    assign fin_f = in_first;
    assign fin_l = in_last;
  end else begin : g_fin_reg
    assign fin_v = v_q[PR-1];
    assign fin_f = f_q[PR-1];
    assign fin_l = l_q[PR-1];
  end

  logic [OUT_W-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [OUT_W-1:0] os_q, os_d, oc_q, oc_d;
  logic [7:0]       ob_q, ob_d;

  logic [OUT_W-1:0] t0, t1, a_s, a_c, s1, c1, s2, c2;
  logic [7:0]       base_cnt, beats_inc;

  assign t0 = g_lvl[L].nx[0];
  assign t1 = g_lvl[L].nx[1];

  // 4:2 compressor merges the tree pair with the running group pair.
  always_comb begin
    a_s       = fin_f ? '0 : acc_s_q;
    a_c       = fin_f ? '0 : acc_c_q;
    base_cnt  = fin_f ? '0 : cnt_q;
    beats_inc = (base_cnt == 8'hFF) ? 8'hFF : base_cnt + 8'd1;
    s1 = t0 ^ t1 ^ a_s;
    c1 = ((t0 & t1) | (t0 & a_s) | (t1 & a_s)) << 1;
    s2 = s1 ^ c1 ^ a_c;
    c2 = ((s1 & c1) | (s1 & a_c) | (c1 & a_c)) << 1;

    acc_s_d = acc_s_q;
    acc_c_d = acc_c_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    os_d    = os_q;
    oc_d    = oc_q;
    ob_d    = ob_q;
    if (adv) begin
      ov_d = 1'b0;
      if (fin_v) begin
        if (fin_l) begin
          os_d    = s2;
          oc_d    = c2;
          ob_d    = beats_inc;
          ov_d    = 1'b1;
          acc_s_d = '0;
          acc_c_d = '0;
          cnt_d   = '0;
        end else begin
          acc_s_d = s2;
          acc_c_d = c2;
          cnt_d   = beats_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      f_q     <= '0;
      l_q     <= '0;
      acc_s_q <= '0;
      acc_c_q <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      os_q    <= '0;
      oc_q    <= '0;
      ob_q    <= '0;
    end else begin
      if (adv) begin
        v_q[0] <= in_valid;
        f_q[0] <= in_first;
        l_q[0] <= in_last;
        for (int unsigned s = 1; s < PR; s++) begin
          v_q[s] <= v_q[s-1];
          f_q[s] <= f_q[s-1];
          l_q[s] <= l_q[s-1];
        end
      end
      acc_s_q <= acc_s_d;
      acc_c_q <= acc_c_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      os_q    <= os_d;
      oc_q    <= oc_d;
      ob_q    <= ob_d;
    end
  end

  assign out_valid = ov_q;
  assign out_sum   = os_q;
  assign out_carry = oc_q;
  assign out_beats = ob_q;

endmodule

// File: tb/tb_pp_reduce_pipe.sv
// Directed and randomized self-checking bench for pp_reduce_pipe.
module tb_pp_reduce_pipe;

  localparam int unsigned N_OPS = 18;
  localparam int unsigned IN_W  = 49;
  localparam int unsigned OUT_W = 56;
  localparam int unsigned PW    = N_OPS*IN_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic             out_ready = 1'b1;
  logic [PW-1:0]    in_pp = '0;
  logic             in_ready, out_valid;
  logic [OUT_W-1:0] out_sum, out_carry;
  logic [7:0]       out_beats;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [OUT_W-1:0] obs_v[$];
  logic [7:0]       obs_b[$];
  logic [OUT_W-1:0] exp_v[$];
  logic [7:0]       exp_b[$];
  logic [OUT_W-1:0] m_sum = '0;
  int unsigned      m_cnt = 0;
  logic [OUT_W-1:0] tot;
  bit               done;

  pp_reduce_pipe #(.SIG_WIDTH(23), .N_OPS(18), .OUT_W(56), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_pp(in_pp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  always_comb tot = out_sum + out_carry;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      obs_v.push_back(tot);
      obs_b.push_back(out_beats);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] fill(input logic [IN_W-1:0] v);
    logic [PW-1:0] r;
    for (int k = 0; k < N_OPS; k++) r[k*IN_W +: IN_W] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] rand_ops();
    logic [PW-1:0] r;
    logic [63:0]   x;
    for (int k = 0; k < N_OPS; k++) begin
      x = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) x = '1;
      r[k*IN_W +: IN_W] = x[IN_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] op_sum(input logic [PW-1:0] v);
    logic [OUT_W-1:0] s;
    s = '0;
    for (int k = 0; k < N_OPS; k++) s = s + OUT_W'(v[k*IN_W +: IN_W]);
    return s;
  endfunction

  task automatic send_beat(input logic f, input logic l, input logic [PW-1:0] ops);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_pp    = ops;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout got=no_accept want=accept");
    end else begin
      if (f) begin
        m_sum = '0;
        m_cnt = 0;
      end
      m_sum = m_sum + op_sum(ops);
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (l) begin
        exp_v.push_back(m_sum);
        exp_b.push_back(8'(m_cnt));
        m_sum = '0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic wait_results(input int unsigned n);
    for (int t = 0; t < 20000 && obs_v.size() < n; t++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    obs_v.delete();
    obs_b.delete();
    exp_v.delete();
    exp_b.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL rst_out_sum got=%h want=0", out_sum); end
    n_cmp++; if (out_carry !== '0) begin n_bad++; $display("FAIL rst_out_carry got=%h want=0", out_carry); end
    n_cmp++; if (out_beats !== 8'd0) begin n_bad++; $display("FAIL rst_out_beats got=%0d want=0", out_beats); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
    rst_n = 1'b1;
    m_sum = '0;
    m_cnt = 0;
  endtask

  task automatic test_single();
    logic [PW-1:0] v;
    for (int k = 0; k < N_OPS; k++) v[k*IN_W +: IN_W] = IN_W'(k + 1);
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    in_pp    = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got=%0b want=0", out_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%0b want=1", out_valid); end
    n_cmp++; if (tot !== 56'd171) begin n_bad++; $display("FAIL single_sum got=%0d want=171", tot); end
    n_cmp++; if (out_beats !== 8'd1) begin n_bad++; $display("FAIL single_beats got=%0d want=1", out_beats); end
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_consumed got=%0b want=0", out_valid); end
    clear_queues();
  endtask

  task automatic test_group();
    clear_queues();
    send_beat(1'b1, 1'b0, fill(49'h1_FFFF_FFFF_FFFF));
    send_beat(1'b0, 1'b0, fill(49'h1_FFFF_FFFF_FFFF));
    send_beat(1'b0, 1'b1, fill(49'h1_FFFF_FFFF_FFFF));
    wait_results(1);
    n_cmp++; if (obs_v.size() != 1) begin n_bad++; $display("FAIL group_count got=%0d want=1", obs_v.size()); end
    if (obs_v.size() > 0) begin
      n_cmp++; if (obs_v[0] !== 56'h6B_FFFF_FFFF_FFCA) begin n_bad++; $display("FAIL group_sum got=%h want=6bffffffffffca", obs_v[0]); end
      n_cmp++; if (obs_b[0] !== 8'd3) begin n_bad++; $display("FAIL group_beats got=%0d want=3", obs_b[0]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(1'b1, 1'b1, fill(IN_W'(i + 1)));
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid got=%0b want=1", out_valid); end
          n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got=%0b want=0", in_ready); end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_results(10);
    n_cmp++; if (obs_v.size() != 10) begin n_bad++; $display("FAIL b2b_count got=%0d want=10", obs_v.size()); end
    for (int i = 0; i < 10 && i < obs_v.size(); i++) begin
      n_cmp++; if (obs_v[i] !== OUT_W'(18*(i + 1))) begin n_bad++; $display("FAIL b2b_sum[%0d] got=%0d want=%0d", i, obs_v[i], 18*(i + 1)); end
      n_cmp++; if (obs_b[i] !== 8'd1) begin n_bad++; $display("FAIL b2b_beats[%0d] got=%0d want=1", i, obs_b[i]); end
    end
  endtask

  task automatic test_restart();
    clear_queues();
    send_beat(1'b1, 1'b0, fill(49'd5));
    send_beat(1'b0, 1'b0, fill(49'd9));
    send_beat(1'b1, 1'b1, fill(49'd1));
    wait_results(1);
    n_cmp++; if (obs_v.size() != 1) begin n_bad++; $display("FAIL restart_count got=%0d want=1", obs_v.size()); end
    if (obs_v.size() > 0) begin
      n_cmp++; if (obs_v[0] !== 56'd18) begin n_bad++; $display("FAIL restart_sum got=%0d want=18", obs_v[0]); end
      n_cmp++; if (obs_b[0] !== 8'd1) begin n_bad++; $display("FAIL restart_beats got=%0d want=1", obs_b[0]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    send_beat(1'b1, 1'b0, fill(49'd7));
    send_beat(1'b0, 1'b0, fill(49'd7));
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%0b want=0", out_valid); end
    n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL midrst_sum got=%h want=0", out_sum); end
    n_cmp++; if (out_carry !== '0) begin n_bad++; $display("FAIL midrst_carry got=%h want=0", out_carry); end
    n_cmp++; if (out_beats !== 8'd0) begin n_bad++; $display("FAIL midrst_beats got=%0d want=0", out_beats); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_sum = '0;
    m_cnt = 0;
    send_beat(1'b0, 1'b1, fill(49'd2));
    send_beat(1'b1, 1'b1, fill(49'd3));
    wait_results(2);
    n_cmp++; if (obs_v.size() != 2) begin n_bad++; $display("FAIL midrst_count got=%0d want=2", obs_v.size()); end
    if (obs_v.size() > 1) begin
      n_cmp++; if (obs_v[0] !== 56'd36) begin n_bad++; $display("FAIL midrst_first_sum got=%0d want=36", obs_v[0]); end
      n_cmp++; if (obs_b[0] !== 8'd1) begin n_bad++; $display("FAIL midrst_first_beats got=%0d want=1", obs_b[0]); end
      n_cmp++; if (obs_v[1] !== 56'd54) begin n_bad++; $display("FAIL midrst_second_sum got=%0d want=54", obs_v[1]); end
    end
  endtask

  task automatic test_random();
    int unsigned sent;
    int unsigned glen;
    bit          open_grp, abandon, f0;
    clear_queues();
    m_sum = '0;
    m_cnt = 0;
    sent = 0;
    open_grp = 1'b0;
    done = 1'b0;
    fork
      begin
        while (sent < 10000) begin
          glen    = $urandom_range(1, 8);
          abandon = ($urandom_range(0, 9) == 0);
          f0      = open_grp ? 1'b1 : ($urandom_range(0, 3) != 0);
          for (int j = 0; j < glen; j++) begin
            if ($urandom_range(0, 4) == 0) begin
              @(posedge clk);
              #1;
            end
            send_beat((j == 0) ? f0 : 1'b0, (j == glen - 1) && !abandon, rand_ops());
            sent++;
          end
          open_grp = abandon;
        end
        for (int j = 0; j < 300; j++) send_beat(j == 0, j == 299, rand_ops());
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_results(exp_v.size());
    n_cmp++; if (obs_v.size() != exp_v.size()) begin n_bad++; $display("FAIL rand_count got=%0d want=%0d", obs_v.size(), exp_v.size()); end
    for (int i = 0; i < exp_v.size() && i < obs_v.size(); i++) begin
      n_cmp++; if (obs_v[i] !== exp_v[i]) begin n_bad++; $display("FAIL rand_sum[%0d] got=%h want=%h", i, obs_v[i], exp_v[i]); end
      n_cmp++; if (obs_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL rand_beats[%0d] got=%0d want=%0d", i, obs_b[i], exp_b[i]); end
    end
    if (obs_b.size() > 0) begin
      n_cmp++; if (obs_b[obs_b.size()-1] !== 8'd255) begin n_bad++; $display("FAIL sat_beats got=%0d want=255", obs_b[obs_b.size()-1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_group();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
